wf_multi_ctrl: RTL

WF_MULTI_CTRL -- requirements
Module: wf_multi_ctrl

---
 rtl/wf_pkg.sv | 18 +
 rtl/wf_ram_wr_if.sv | 55 +++++
 rtl/wf_multi_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/wf_pkg.sv
// Shared definitions for the waveform controller: FSM state encoding and the
// channel-index width helper used by the top and the RAM write interface.
package wf_pkg;

  localparam int WF_STATE_W = 2;

  typedef enum logic [WF_STATE_W-1:0] {
    WF_IDLE   = 2'd0,
    WF_RUN    = 2'd1,
    WF_REWIND = 2'd2,
    WF_DONE   = 2'd3
  } wf_state_e;

  function automatic int wf_ch_w(input int ch_num);
    return (ch_num > 1) ? $clog2(ch_num) : 1;
  endfunction

endpackage

// File: rtl/wf_ram_wr_if.sv
// Sample write port: gates write requests by FSM permission and channel range,
// and presents accepted writes to the external RAM one cycle later.
module wf_ram_wr_if
  import wf_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  localparam int CH_W  = wf_ch_w(CH_NUM)
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   wr_allow,
  input  logic                   wr_en,
  input  logic [CH_W-1:0]        wr_ch,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  output logic [CH_W+ADDR_W-1:0] ram_addr,
  output logic                   ram_ce,
  output logic                   ram_we,
  output logic [DATA_W-1:0]      ram_din,
  output logic                   wr_drop
);

  logic                   ch_ok;
  logic                   wr_accept;
  logic                   strobe_reg;
  logic [CH_W+ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0]      din_reg;

  // Channel indices can exceed CH_NUM when CH_NUM is not a power of two.
  assign ch_ok     = (32'(wr_ch) < CH_NUM);
  assign wr_accept = wr_en && wr_allow && ch_ok;
  assign wr_drop   = wr_en && !wr_accept;

  always_ff @(posedge clk) begin
    if (srst) begin
      strobe_reg <= 1'b0;
      addr_reg   <= '0;
      din_reg    <= '0;
    end else begin
      strobe_reg <= wr_accept;
      if (wr_accept) begin
        addr_reg <= {wr_ch, wr_addr};
        din_reg  <= wr_data;
      end
    end
  end

  assign ram_addr = addr_reg;
  assign ram_ce   = strobe_reg;
  assign ram_we   = strobe_reg;
  assign ram_din  = din_reg;

endmodule

// File: rtl/wf_multi_ctrl.sv
// Multi-channel waveform playback controller: sample loading, pass sequencing
// and DSP handshake. Define WF_LOOP_EN to enable multi-pass (rewind) playback.
module wf_multi_ctrl
  import wf_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32,
  localparam int CH_W  = wf_ch_w(CH_NUM)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wf_start,
  input  logic                   i_wf_stop,
  input  logic                   i_wf_write_en,
  input  logic [CH_W-1:0]        i_wf_write_ch,
  input  logic [ADDR_W-1:0]      i_wf_write_addr,
  input  logic [DATA_W-1:0]      i_wf_write_data,
  input  logic [CNT_W-1:0]       i_wf_max_cnt,
  input  logic [CNT_W-1:0]       i_wf_read_cnt,
  input  logic [15:0]            i_wf_loop_num,
  output logic [CH_W+ADDR_W-1:0] o_xintf_wf_ram_addr,
  output logic                   o_xintf_wf_ram_ce,
  output logic                   o_xintf_wf_ram_we,
  output logic [DATA_W-1:0]      o_xintf_wf_ram_din,
  output logic                   o_dsp_wf_mode,
  output logic                   o_wf_rewind,
  output logic                   o_wf_done,
  output logic                   o_wf_err,
  output logic [WF_STATE_W-1:0]  o_wf_state,
  output logic [15:0]            o_wf_loop_cnt
);

  wf_state_e        state_reg, state_next;
  logic             start_prev_reg;
  logic [CNT_W-1:0] max_cnt_reg, max_cnt_next;
  logic [15:0]      loop_cnt_reg, loop_cnt_next, loop_cnt_inc;
  logic             err_reg, err_next;
  logic             rewind_reg, rewind_next;
  logic             start_rise, start_ok, pass_end, last_pass;
  logic             wr_allow, wr_drop;

  assign start_rise   = i_wf_start && !start_prev_reg;
  assign start_ok     = (state_reg == WF_IDLE) && start_rise && (i_wf_max_cnt != '0);
  assign pass_end     = (i_wf_read_cnt >= max_cnt_reg);
  assign loop_cnt_inc = (loop_cnt_reg == 16'hFFFF) ? loop_cnt_reg : loop_cnt_reg + 16'd1;
  assign wr_allow     = (state_reg == WF_IDLE) || (state_reg == WF_DONE);

`ifdef WF_LOOP_EN
  logic [15:0] loop_num_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      loop_num_reg <= '0;
    end else if (start_ok) begin
      loop_num_reg <= i_wf_loop_num;
    end
  end

  // A latched loop count of zero never matches, so playback repeats until stopped.
  assign last_pass = (loop_num_reg != 16'd0) && (loop_cnt_inc == loop_num_reg);
`else
  logic unused_loop_num;
  assign unused_loop_num = ^i_wf_loop_num;
  assign last_pass       = 1'b1;
`endif

  always_comb begin
    state_next    = state_reg;
    max_cnt_next  = max_cnt_reg;
    loop_cnt_next = loop_cnt_reg;
    err_next      = err_reg;
    rewind_next   = 1'b0;
    case (state_reg)
      WF_IDLE: begin
        if (start_rise) begin
          if (i_wf_max_cnt == '0) begin
            err_next = 1'b1;
          end else begin
            max_cnt_next  = i_wf_max_cnt;
            loop_cnt_next = '0;
            err_next      = 1'b0;
            state_next    = WF_RUN;
          end
        end
      end
      WF_RUN: begin
        if (i_wf_stop) begin
          state_next = WF_DONE;
        end else if (pass_end) begin
          loop_cnt_next = loop_cnt_inc;
          if (last_pass) begin
            state_next = WF_DONE;
          end else begin
            rewind_next = 1'b1;
            state_next  = WF_REWIND;
          end
        end
      end
      WF_REWIND: begin
        if (i_wf_stop) begin
          state_next = WF_DONE;
        end else if (i_wf_read_cnt == '0) begin
          state_next = WF_RUN;
        end
      end
      WF_DONE: begin
        if (!i_wf_start) begin
          state_next = WF_IDLE;
        end
      end
      default: state_next = WF_IDLE;
    endcase
    // A dropped write flags an error even in the cycle a start clears it.
    if (wr_drop) begin
      err_next = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= WF_IDLE;
      start_prev_reg <= 1'b0;
      max_cnt_reg    <= '0;
      loop_cnt_reg   <= '0;
      err_reg        <= 1'b0;
      rewind_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      start_prev_reg <= i_wf_start;
      max_cnt_reg    <= max_cnt_next;
      loop_cnt_reg   <= loop_cnt_next;
      err_reg        <= err_next;
      rewind_reg     <= rewind_next;
    end
  end

  wf_ram_wr_if #(
    .CH_NUM (CH_NUM),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr_if (
    .clk      (i_clk),
    .srst     (i_rst),
    .wr_allow (wr_allow),
    .wr_en    (i_wf_write_en),
    .wr_ch    (i_wf_write_ch),
    .wr_addr  (i_wf_write_addr),
    .wr_data  (i_wf_write_data),
    .ram_addr (o_xintf_wf_ram_addr),
    .ram_ce   (o_xintf_wf_ram_ce),
    .ram_we   (o_xintf_wf_ram_we),
    .ram_din  (o_xintf_wf_ram_din),
    .wr_drop  (wr_drop)
  );

  assign o_dsp_wf_mode = (state_reg == WF_RUN) || (state_reg == WF_REWIND);
  assign o_wf_rewind   = rewind_reg;
  assign o_wf_done     = (state_reg == WF_DONE);
  assign o_wf_err      = err_reg;
  assign o_wf_state    = state_reg;
  assign o_wf_loop_cnt = loop_cnt_reg;

endmodule
